inv_mix_col_seq: RTL and testbench

Iterative AES InvMixColumns unit for the decryption datapath, the inverse of the encryption-side MixColumns stage. It accepts a 128-bit state over a valid/ready handshake and multiplies each 32-bit column by the inverse matrix {0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e} over GF(2^8). It processes one column per clock, so four GF multiplier columns collapse to one shared column datapath. It sits between AddRoundKey and InvShiftRows/InvSubBytes in the round loop of the decryption core.

---
 rtl/inv_mix_col_seq_if.sv | 21 ++
 rtl/inv_mix_col_seq.sv | 118 +++++++++++
 tb/tb_inv_mix_col_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_mix_col_seq_if.sv
// rtl/inv_mix_col_seq_if.sv - handshake bundle for the iterative InvMixColumns unit
interface inv_mix_col_seq_if;
  logic           in_valid;
  logic           in_ready;
  logic [0:127]   data_in;
  logic           bypass_in;
  logic           out_valid;
  logic           out_ready;
  logic [0:127]   data_out;
  logic           busy;

  modport master (
    output in_valid, data_in, bypass_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, data_in, bypass_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/inv_mix_col_seq.sv
// rtl/inv_mix_col_seq.sv - AES InvMixColumns, one column per clock over a shared GF datapath
module inv_mix_col_seq (
  input  logic               clk,
  input  logic               rst_n,
  inv_mix_col_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [0:127]  st_q, st_d;
  logic          byp_q, byp_d;
  logic          out_valid_q, out_valid_d;
  logic [6:0]    col_base;
  logic [31:0]   col_in;
  logic [31:0]   col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse-matrix coefficients as xtime chains; sel: 0=09 1=0b 2=0d 3=0e
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [1:0] sel);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (sel)
      2'd0:    return x8 ^ a;
      2'd1:    return x8 ^ x2 ^ a;
      2'd2:    return x8 ^ x4 ^ a;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = gf_mul(a0, 2'd3) ^ gf_mul(a1, 2'd1) ^ gf_mul(a2, 2'd2) ^ gf_mul(a3, 2'd0);
    r1 = gf_mul(a0, 2'd0) ^ gf_mul(a1, 2'd3) ^ gf_mul(a2, 2'd1) ^ gf_mul(a3, 2'd2);
    r2 = gf_mul(a0, 2'd2) ^ gf_mul(a1, 2'd0) ^ gf_mul(a2, 2'd3) ^ gf_mul(a3, 2'd1);
    r3 = gf_mul(a0, 2'd1) ^ gf_mul(a1, 2'd2) ^ gf_mul(a2, 2'd0) ^ gf_mul(a3, 2'd3);
    return {r0, r1, r2, r3};
  endfunction

  assign col_base = {col_q, 5'd0};
  assign col_in   = st_q[col_base +: 32];
  assign col_out  = inv_mix_col(col_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      st_q        <= '0;
      byp_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      st_q        <= st_d;
      byp_q       <= byp_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    st_d        = st_q;
    byp_d       = byp_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          st_d    = bus.data_in;
          byp_d   = bus.bypass_in;
          col_d   = 2'd0;
          state_d = bus.bypass_in ? DONE : BUSY;
        end
      end
      BUSY: begin
        st_d[col_base +: 32] = col_out;
        col_d                = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        // A bypassed state spends one settle cycle in DONE before it is presented
        out_valid_d = out_valid_q | byp_q;
        if (out_valid_q && bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          byp_d       = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = st_q;

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// tb/tb_inv_mix_col_seq.sv - scoreboard bench for inv_mix_col_seq against a matrix reference
module tb_inv_mix_col_seq;

  typedef logic [0:127] st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_mix_col_seq_if bus ();

  inv_mix_col_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_recv = 0;

  st_t exp_q[$];
  st_t in_q[$];
  bit  byp_fifo[$];

  st_t mon_e, mon_i;
  bit  mon_b;

  // Generic shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a, p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  // Circulant matrix product on every column; first row is {k0 k1 k2 k3}
  function automatic st_t mat_cols(input st_t s, input logic [7:0] k0, k1, k2, k3);
    logic [7:0] coef [4];
    logic [7:0] acc;
    st_t o;
    coef[0] = k0; coef[1] = k1; coef[2] = k2; coef[3] = k3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - r + 4) % 4], s[32*c + 8*k +: 8]);
        o[32*c + 8*r +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic st_t inv_ref(input st_t s);
    return mat_cols(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic st_t fwd_ref(input st_t s);
    return mat_cols(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %h required no output", bus.data_out);
      end else begin
        mon_e = exp_q.pop_front();
        mon_i = in_q.pop_front();
        mon_b = byp_fifo.pop_front();
        check("result", bus.data_out, mon_e);
        if (!mon_b) check("mixcolumns_roundtrip", fwd_ref(bus.data_out), mon_i);
        n_recv++;
      end
    end
  end

  // Called one step after a rising edge; returns one step after the accepting edge
  task automatic send(input st_t d, input st_t e, input bit byp);
    int wait_cyc;
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    bus.bypass_in = byp;
    wait_cyc = 0;
    while (!bus.in_ready && wait_cyc < 300) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 required 1 within 300 cycles");
    end else begin
      exp_q.push_back(e);
      in_q.push_back(d);
      byp_fifo.push_back(byp);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic measure(input int req_lat, input int req_busy, input string tag);
    int n, nb;
    n = 0;
    nb = 0;
    while (!bus.out_valid && n < 20) begin
      if (bus.busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(req_lat));
    check({tag, "_busy_cycles"}, 128'(nb), 128'(req_busy));
  endtask

  initial begin
    st_t v, e;
    int base, cyc;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.bypass_in = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_busy", 128'(bus.busy), 128'(0));
    check("reset_data_out", bus.data_out, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", 128'(bus.in_ready), 128'(1));

    // FIPS-197 columns
    bus.out_ready = 1'b1;
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    measure(4, 4, "fips");
    @(posedge clk); #1;
    check("fips_in_ready_after_retire", 128'(bus.in_ready), 128'(1));

    send(128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff, 128'h2d26314c_d4d4d4d5_00000000_ffffffff, 1'b0);
    measure(4, 4, "vec2");
    @(posedge clk); #1;

    // Bypass
    send(128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210, 1'b1);
    measure(1, 0, "bypass");
    @(posedge clk); #1;
    check("bypass_in_ready_after_retire", 128'(bus.in_ready), 128'(1));

    // Backpressure in DONE
    bus.out_ready = 1'b0;
    v = {$urandom, $urandom, $urandom, $urandom};
    e = inv_ref(v);
    send(v, e, 1'b0);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = ~bus.in_valid;
      bus.data_in   = {$urandom, $urandom, $urandom, $urandom};
      bus.bypass_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("stall_out_valid", 128'(bus.out_valid), 128'(1));
      check("stall_data_out", bus.data_out, e);
      check("stall_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_in_ready", 128'(bus.in_ready), 128'(1));
    check("release_out_valid", 128'(bus.out_valid), 128'(0));

    // Reset mid-BUSY
    bus.out_ready = 1'b1;
    send(128'hdeadbeef_cafef00d_12345678_9abcdef0, inv_ref(128'hdeadbeef_cafef00d_12345678_9abcdef0), 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midbusy_reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("midbusy_reset_busy", 128'(bus.busy), 128'(0));
    check("midbusy_reset_data_out", bus.data_out, 128'h0);
    exp_q.delete();
    in_q.delete();
    byp_fifo.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midbusy_release_in_ready", 128'(bus.in_ready), 128'(1));
    repeat (6) @(posedge clk);
    #1;
    check("midbusy_no_output", 128'(bus.out_valid), 128'(0));

    // Back-to-back random stream with randomized out_ready
    base = n_recv;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          st_t s;
          bit b;
          if (i == 0) s = '0;
          else if (i == 1) s = '1;
          else s = {$urandom, $urandom, $urandom, $urandom};
          b = (i >= 2) && ($urandom_range(0, 3) == 0);
          send(s, b ? s : inv_ref(s), b);
        end
      end
      begin
        cyc = 0;
        while (n_recv < base + 40 && cyc < 5000) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          cyc++;
        end
      end
    join
    check("stream_count", 128'(n_recv - base), 128'(40));
    check("stream_leftover", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
